// File: rtl/uart_rx_top_module.sv
// UART receiver: 16x oversampled baud ticks, 2-flop input synchronizer and
// start/data/parity/stop deframing FSM with a one-cycle receive strobe.
module uart_rx_top_module #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] baud_rate,
  input  logic       din,
  input  logic [1:0] parity_type,
  output logic       recieve_flag,
  output logic [7:0] out,
  output logic       parity_bit
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [19:0] DIV0_LAST = 20'(CLK_FREQ / (2400  * OVERSAMPLE) - 1);
  localparam logic [19:0] DIV1_LAST = 20'(CLK_FREQ / (4800  * OVERSAMPLE) - 1);
  localparam logic [19:0] DIV2_LAST = 20'(CLK_FREQ / (9600  * OVERSAMPLE) - 1);
  localparam logic [19:0] DIV3_LAST = 20'(CLK_FREQ / (19200 * OVERSAMPLE) - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic          din_s1_q, din_s2_q, din_prev_q;
  logic [19:0]   div_cnt_q, div_cnt_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_rx_q, par_rx_d;
  logic [1:0]    baud_q, baud_d;
  logic [1:0]    ptype_q, ptype_d;
  logic [7:0]    out_q, out_d;
  logic          pbit_q, pbit_d;
  logic          flag_q, flag_d;

  logic [19:0] div_last;
  logic        tick;
  logic        div_restart;
  logic        par_en;
  logic        par_ok;

  always_comb begin
    case (baud_q)
      2'b00:   div_last = DIV0_LAST;
      2'b01:   div_last = DIV1_LAST;
      2'b10:   div_last = DIV2_LAST;
      default: div_last = DIV3_LAST;
    endcase
  end

  assign tick   = (div_cnt_q == div_last);
  assign par_en = (ptype_q == 2'b01) || (ptype_q == 2'b10);
  // Odd parity wants the XOR over data and parity to be 1, even wants 0.
  assign par_ok = !par_en || ((^shift_q ^ par_rx_q) == (ptype_q == 2'b01));

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_rx_d    = par_rx_q;
    baud_d      = baud_q;
    ptype_d     = ptype_q;
    out_d       = out_q;
    pbit_d      = pbit_q;
    flag_d      = 1'b0;
    div_restart = 1'b0;

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        // Needs a high->low transition, so a line stuck low never retriggers.
        if (din_prev_q && !din_s2_q) begin
          state_d     = START;
          baud_d      = baud_rate;
          ptype_d     = parity_type;
          div_restart = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == MID_TICK) begin
            tick_cnt_d = '0;
            state_d    = din_s2_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            shift_d    = {din_s2_q, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = par_en ? PARITY : STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            par_rx_d   = din_s2_q;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
            if (din_s2_q && par_ok) begin
              out_d  = shift_q;
              pbit_d = par_en ? par_rx_q : 1'b0;
              flag_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (div_restart || tick) div_cnt_d = '0;
    else                     div_cnt_d = div_cnt_q + 20'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      din_s1_q   <= 1'b1;
      din_s2_q   <= 1'b1;
      din_prev_q <= 1'b1;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_rx_q   <= 1'b0;
      baud_q     <= 2'b00;
      ptype_q    <= 2'b00;
      out_q      <= 8'h00;
      pbit_q     <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_s1_q   <= din;
      din_s2_q   <= din_s1_q;
      din_prev_q <= din_s2_q;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_rx_q   <= par_rx_d;
      baud_q     <= baud_d;
      ptype_q    <= ptype_d;
      out_q      <= out_d;
      pbit_q     <= pbit_d;
      flag_q     <= flag_d;
    end
  end

  assign recieve_flag = flag_q;
  assign out          = out_q;
  assign parity_bit   = pbit_q;

endmodule

// File: tb/tb_uart_rx_top_module.sv
// Self-checking bench for uart_rx_top_module; clock frequency is scaled down
// so every baud divisor is exact (32/16/8/4) and frames stay short.
module tb_uart_rx_top_module;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] baud_rate;
  logic       din;
  logic [1:0] parity_type;
  logic       recieve_flag;
  logic [7:0] out;
  logic       parity_bit;

  int checks = 0;
  int failures = 0;
  int flag_count = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  uart_rx_top_module #(.CLK_FREQ(1_228_800), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .baud_rate(baud_rate), .din(din),
    .parity_type(parity_type), .recieve_flag(recieve_flag), .out(out),
    .parity_bit(parity_bit)
  );

  always #5 clk = ~clk;

  // Scoreboard: every strobe must match the oldest expected {parity, byte}.
  always @(negedge clk) begin
    if (!reset && recieve_flag) begin
      flag_count = flag_count + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_flag got out=%h parity=%b, required no flag", out, parity_bit);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({parity_bit, out} !== mon_exp) begin
          failures = failures + 1;
          $display("FAIL rx_frame got out=%h parity=%b, required out=%h parity=%b",
                   out, parity_bit, mon_exp[7:0], mon_exp[8]);
        end else begin
          $display("rx frame out=%h parity=%b", out, parity_bit);
        end
      end
    end
  end

  function automatic int bit_clks(input logic [1:0] br);
    return 16 * (32 >> br);
  endfunction

  task automatic send_frame(input logic [7:0] data, input logic [1:0] br,
                            input logic [1:0] pt, input logic p, input logic stop);
    int bc;
    logic pen, valid;
    baud_rate = br;
    parity_type = pt;
    bc = bit_clks(br);
    pen = (pt == 2'b01) || (pt == 2'b10);
    valid = stop && (!pen || ((^data ^ p) == (pt == 2'b01)));
    if (valid) exp_q.push_back({pen ? p : 1'b0, data});
    $display("tx frame data=%h baud=%0d ptype=%0d p=%b stop=%b expect_valid=%b",
             data, br, pt, p, stop, valid);
    din = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = data[i];
      repeat (bc) @(negedge clk);
    end
    if (pen) begin
      din = p;
      repeat (bc) @(negedge clk);
    end
    din = stop;
    repeat (bc) @(negedge clk);
    din = 1'b1;
  endtask

  task automatic test_reset;
    int f0;
    reset = 1'b1; din = 1'b1; baud_rate = 2'b00; parity_type = 2'b00;
    repeat (10) @(negedge clk);
    checks++; if (out !== 8'h00) begin failures++; $display("FAIL reset_out got %h required 00", out); end
    checks++; if (parity_bit !== 1'b0) begin failures++; $display("FAIL reset_parity got %b required 0", parity_bit); end
    checks++; if (recieve_flag !== 1'b0) begin failures++; $display("FAIL reset_flag got %b required 0", recieve_flag); end
    reset = 1'b0;
    f0 = flag_count;
    repeat (2000) @(negedge clk);
    checks++; if (flag_count !== f0) begin failures++; $display("FAIL idle_no_flag got %0d flags required 0", flag_count - f0); end
    $display("test_reset done");
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout got %0d pending frames required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_odd_parity;
    int f0;
    f0 = flag_count;
    send_frame(8'hA5, 2'b10, 2'b01, 1'b1, 1'b1);
    drain("odd");
    repeat (20) @(negedge clk);
    checks++; if (flag_count - f0 !== 1) begin failures++; $display("FAIL odd_flags got %0d required 1", flag_count - f0); end
    checks++; if (out !== 8'hA5) begin failures++; $display("FAIL odd_out got %h required a5", out); end
    checks++; if (parity_bit !== 1'b1) begin failures++; $display("FAIL odd_parity got %b required 1", parity_bit); end
  endtask

  task automatic test_even_parity;
    int f0;
    f0 = flag_count;
    send_frame(8'h3C, 2'b00, 2'b10, 1'b0, 1'b1);
    drain("even");
    repeat (20) @(negedge clk);
    checks++; if (flag_count - f0 !== 1) begin failures++; $display("FAIL even_flags got %0d required 1", flag_count - f0); end
    checks++; if (parity_bit !== 1'b0) begin failures++; $display("FAIL even_parity got %b required 0", parity_bit); end
    f0 = flag_count;
    send_frame(8'h3C, 2'b00, 2'b10, 1'b1, 1'b1);
    repeat (600) @(negedge clk);
    checks++; if (flag_count !== f0) begin failures++; $display("FAIL even_bad_flag got %0d flags required 0", flag_count - f0); end
    checks++; if (out !== 8'h3C) begin failures++; $display("FAIL even_bad_out got %h required 3c", out); end
  endtask

  task automatic test_back_to_back;
    int f0;
    f0 = flag_count;
    send_frame(8'h01, 2'b11, 2'b00, 1'b0, 1'b1);
    send_frame(8'hFF, 2'b11, 2'b00, 1'b0, 1'b1);
    drain("b2b");
    repeat (20) @(negedge clk);
    checks++; if (flag_count - f0 !== 2) begin failures++; $display("FAIL b2b_flags got %0d required 2", flag_count - f0); end
    checks++; if (out !== 8'hFF) begin failures++; $display("FAIL b2b_out got %h required ff", out); end
    checks++; if (parity_bit !== 1'b0) begin failures++; $display("FAIL b2b_parity got %b required 0", parity_bit); end
  endtask

  task automatic test_glitch_framing;
    int f0;
    f0 = flag_count;
    baud_rate = 2'b00; parity_type = 2'b00;
    din = 1'b0;
    repeat (200) @(negedge clk);
    din = 1'b1;
    repeat (800) @(negedge clk);
    checks++; if (flag_count !== f0) begin failures++; $display("FAIL glitch_flag got %0d flags required 0", flag_count - f0); end
    send_frame(8'h55, 2'b00, 2'b00, 1'b0, 1'b0);
    repeat (600) @(negedge clk);
    checks++; if (flag_count !== f0) begin failures++; $display("FAIL framing_flag got %0d flags required 0", flag_count - f0); end
    checks++; if (out !== 8'hFF) begin failures++; $display("FAIL framing_out got %h required ff", out); end
  endtask

  task automatic test_reset_mid_frame;
    int f0, bc;
    logic [7:0] data;
    data = 8'h81;
    f0 = flag_count;
    baud_rate = 2'b10; parity_type = 2'b00;
    bc = bit_clks(2'b10);
    din = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      din = data[i];
      repeat (bc) @(negedge clk);
    end
    din = data[4];
    repeat (bc / 2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (out !== 8'h00) begin failures++; $display("FAIL midreset_out got %h required 00", out); end
    checks++; if (recieve_flag !== 1'b0) begin failures++; $display("FAIL midreset_flag got %b required 0", recieve_flag); end
    din = 1'b1;
    reset = 1'b0;
    repeat (2000) @(negedge clk);
    checks++; if (flag_count !== f0) begin failures++; $display("FAIL midreset_noflag got %0d flags required 0", flag_count - f0); end
    send_frame(8'h81, 2'b10, 2'b00, 1'b0, 1'b1);
    drain("after_reset");
    repeat (20) @(negedge clk);
    checks++; if (out !== 8'h81) begin failures++; $display("FAIL after_reset_out got %h required 81", out); end
    checks++; if (flag_count - f0 !== 1) begin failures++; $display("FAIL after_reset_flags got %0d required 1", flag_count - f0); end
  endtask

  initial begin
    test_reset();
    test_odd_parity();
    test_even_parity();
    test_back_to_back();
    test_glitch_framing();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
